// File: rtl/denoise_axis_pack_if.sv
// AXI4-Stream bundle carrying packed 4-pixel words
// with start-of-frame (tuser) and end-of-line (tlast) tags.
interface denoise_axis_pack_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/denoise_axis_pack.sv
// Packs denoised 8-bit pixels into 32-bit AXI4-Stream words
// through a small word FIFO with sticky overflow reporting.
module denoise_axis_pack #(
    parameter int IMG_WIDTH  = 752,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    input  logic                       frame_begin,
    input  logic                       denoise_valid,
    input  logic [7:0]                 denoise_din,
    denoise_axis_pack_if.master        m_axis,
    output logic                       overflow
);

    localparam int PW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int LW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_HEIGHT - 1);

    logic [PW-1:0] pix_cnt;
    logic [PW-1:0] pix_idx;
    logic [LW-1:0] line_cnt;
    logic [LW-1:0] line_idx;
    logic [23:0]   pbuf;

    logic          push;
    logic          push_ok;
    logic          pop;
    logic          load;
    logic          full;
    logic [33:0]   push_word;

    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] mem_cnt;

    logic          tvalid_q;
    logic [31:0]   tdata_q;
    logic          tuser_q;
    logic          tlast_q;

    // A pixel arriving with frame_begin is pixel 0 of line 0.
    assign pix_idx  = frame_begin ? '0 : pix_cnt;
    assign line_idx = frame_begin ? '0 : line_cnt;

    assign push = denoise_valid && (pix_idx[1:0] == 2'd3);
    assign push_word = {
        pix_idx == PIX_LAST,
        (line_idx == '0) && (pix_idx == PW'(3)),
        denoise_din,
        pbuf
    };

    // cnt covers the memory plus the output register, so total
    // storage is exactly FIFO_DEPTH words.
    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign pop     = tvalid_q && m_axis.tready;
    assign push_ok = push && (!full || pop);
    assign mem_cnt = cnt - CW'(tvalid_q);
    assign load    = (mem_cnt != '0) && (!tvalid_q || pop);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            pbuf     <= '0;
        end else if (denoise_valid) begin
            if (pix_idx == PIX_LAST) begin
                pix_cnt  <= '0;
                line_cnt <= (line_idx == LINE_LAST) ? '0
                          : line_idx + LW'(1);
            end else begin
                pix_cnt  <= pix_idx + PW'(1);
                line_cnt <= line_idx;
            end
            case (pix_idx[1:0])
                2'd0:    pbuf[7:0]   <= denoise_din;
                2'd1:    pbuf[15:8]  <= denoise_din;
                2'd2:    pbuf[23:16] <= denoise_din;
                default: ;
            endcase
        end else if (frame_begin) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cnt <= cnt + CW'(push_ok) - CW'(pop);
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                {tlast_q, tuser_q, tdata_q} <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
                tvalid_q <= 1'b1;
            end else if (pop) begin
                tvalid_q <= 1'b0;
            end
            if (frame_begin) begin
                overflow <= 1'b0;
            end else if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tlast  = tlast_q;

endmodule

// File: doc/denoise_axis_pack.md
DENOISE_AXIS_PACK -- requirements
Module: denoise_axis_pack

Interface
Parameters:
REQ-001 SHALL provide parameter IMG_WIDTH, default 752, meaning pixels per line; it SHALL be a multiple of 4.
REQ-002 SHALL provide parameter IMG_HEIGHT, default 480, meaning lines per frame.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 16, meaning output word FIFO entries; it SHALL be a power of 2.
Ports:
REQ-004 s_axi_aclk  input  1  sole clock; all logic on rising edge.
REQ-005 s_axi_aresetn  input  1  reset, asynchronous, active-low.
REQ-006 frame_begin  input  1  single-cycle frame start pulse, already synchronous to s_axi_aclk.
REQ-007 denoise_valid  input  1  qualifies denoise_din for one pixel per high cycle.
REQ-008 denoise_din  input  8  denoised pixel.
REQ-009 m_axis_tdata  output  32  four packed pixels.
REQ-010 m_axis_tvalid  output  1  AXI4-Stream valid.
REQ-011 m_axis_tready  input  1  AXI4-Stream ready.
REQ-012 m_axis_tuser  output  1  start-of-frame flag on first word of frame.
REQ-013 m_axis_tlast  output  1  end-of-line flag on last word of each line.
REQ-014 overflow  output  1  sticky flag, word dropped because FIFO full.

Function
REQ-015 Pixel counter (0..IMG_WIDTH-1) SHALL advance on each denoise_valid cycle and wrap to 0 after IMG_WIDTH-1, advancing line counter (0..IMG_HEIGHT-1); line counter SHALL wrap to 0 after IMG_HEIGHT-1.
REQ-016 Packing: pixel with index p SHALL occupy byte lane p mod 4, lane 0 = bits [7:0]; word SHALL be complete on the cycle lane 3 is captured.
REQ-017 Complete word tags: tuser = (line 0 and pixel index 3); tlast = (pixel index IMG_WIDTH-1).
REQ-018 Complete word SHALL be pushed into FIFO with tags on the same edge lane 3 is captured.
REQ-019 Push SHALL be accepted if FIFO not full, or if full and a pop occurs in the same cycle.
REQ-020 Push rejected SHALL drop the word and set overflow to 1; overflow SHALL stay 1 until frame_begin or reset.
REQ-021 m_axis_tvalid SHALL equal FIFO non-empty; tdata/tuser/tlast SHALL present the FIFO head, registered.
REQ-022 Pop SHALL occur when m_axis_tvalid and m_axis_tready are both 1; while tvalid=1 and tready=0, tdata/tuser/tlast SHALL hold stable.
REQ-023 Latency: with FIFO empty and tready=1, tvalid SHALL rise one clock after the edge capturing lane 3.
REQ-024 frame_begin SHALL reset pixel counter, line counter and packing lane, discard any partial word, and clear overflow; FIFO contents SHALL be retained and drained.
REQ-025 frame_begin coincident with denoise_valid: that pixel SHALL be treated as pixel 0 of line 0.
REQ-026 Throughput: sustained one pixel per clock SHALL never overflow while tready=1 continuously.
REQ-027 FIFO occupancy arithmetic SHALL be log2(FIFO_DEPTH)+1 bits wide; read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 On s_axi_aresetn=0, immediately and without a clock: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, overflow=0, FIFO emptied, all counters and lane to 0.
REQ-029 Reset mid-line or mid-frame SHALL discard all FIFO contents and partial word; first pixel after release SHALL be pixel 0 of line 0.

Verification
REQ-030 Full frame: frame_begin, then 752x480 continuous valid pixels, value = p mod 256, tready=1 -> 90240 words; tuser only on word 0; tlast on every 188th word; word 0 tdata = 0x03020100; overflow=0.
REQ-031 Backpressure: tready=0 for 10 cycles while 8 words queue -> tvalid held 1, head tdata stable, all 8 words delivered in order after tready=1.
REQ-032 Overflow: tready=0 while 20 words complete (FIFO_DEPTH=16) -> exactly 16 words emitted afterwards, overflow=1; next frame_begin -> overflow=0.
REQ-033 frame_begin after 6 pixels of line 0 -> bytes 4-5 discarded; next complete word carries tuser=1 and contains the 4 pixels following frame_begin.
REQ-034 Simultaneous frame_begin and denoise_valid with din=0xAA -> 0xAA lands in lane 0 of next word, which has tuser=1.
REQ-035 Reset asserted with 5 words in FIFO -> tvalid=0 asynchronously; after release, no stale word emitted.
